kv_ram_loader: RTL and testbench
================================

# kv_ram_loader

Synthesizable loader that streams a byte-serial matrix image into the multi-head K or V BRAM feeding the attention engine. It packs incoming bytes into rows of H heads × N bytes, writes M rows, and owns the RAM address while busy. When idle it passes the attention engine's read address straight through. It replaces bench-only file loading and adds single-head update mode with per-head byte enables.

## Interface
- M, 166, rows per matrix (tokens)
- N, 44, bytes per head per row
- H, 4, heads packed side by side in one RAM word
- AW, $clog2(M), row address width
- HW, $clog2(H) (min 1), head index width
- clk  in  1  sole clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle load request, honoured only in IDLE
- sel_v  in  1  target: 0 = K RAM, 1 = V RAM; latched at start
- one_head  in  1  mode: 0 = all heads (row = H·N bytes), 1 = single head (row = N bytes); latched at start
- head_idx  in  HW  target head in single-head mode; latched at start
- in_valid  in  1  byte valid
- in_data  in  8  byte
- in_ready  out  1  byte accepted when in_valid && in_ready
- dut_K_addr, dut_V_addr  in  AW each  attention engine read addresses
- K_addr, V_addr  out  AW each  RAM addresses
- ram_data  out  H·N·8  write word shared by both RAMs
- ram_be  out  H  per-head write enable, bit h covers bytes [h·N, (h+1)·N)
- K_we, V_we  out  1 each  write strobes
- busy  out  1  loader owns the selected RAM
- done  out  1  one-cycle pulse after the last row is written

## Operation
- States: IDLE, FILL, WRITE, DONE.
- IDLE: if start, latch sel_v/one_head/head_idx, clear row=0 and byte=0, go to FILL.
- FILL: in_ready=1. Each accepted byte is stored at byte slot base+byte, where base = head_idx·N in single-head mode and 0 otherwise. Byte slot j maps to ram_data[8j+:8]. byte increments. When the byte accepted is the row's last (L−1, L = N or H·N), go to WRITE.
- WRITE: in_ready=0. The selected strobe is high for exactly one cycle with addr=row. ram_be = all ones in all-head mode, else one-hot(head_idx). If row==M−1 go to DONE; else row++, byte=0, go to FILL.
- DONE: done=1 for one cycle, then IDLE.
- Slots outside the target head are don't-care in single-head mode (ram_be masks them). Slot contents persist between rows; every enabled slot is rewritten each row.
- Address mux, combinational: K_addr = (busy && !sel_v) ? row : dut_K_addr. V_addr = (busy && sel_v) ? row : dut_V_addr. The unselected RAM always follows the engine.
- busy = state ≠ IDLE.
- start while busy is ignored. head_idx ≥ H in single-head mode is clamped to H−1.
- Reset in any state: return to IDLE, drop any partial row, issue no write.

## Timing
- Reset values: in_ready 0, K_we 0, V_we 0, busy 0, done 0, ram_be 0, ram_data 0, internal row/byte 0.
- Start sampled at cycle 0; FILL and in_ready from cycle 1.
- With in_valid held high: row r bytes accepted in cycles r(L+1)+1 … r(L+1)+L, with the write in cycle (r+1)(L+1).
- done at cycle M(L+1)+1; busy low from M(L+1)+2.
- in_valid gaps stall FILL with no data loss. in_data is sampled only on handshake.
- Write strobe, addr, ram_data and ram_be are registered and stable together during the WRITE cycle.

## Test plan
- Params M=4, N=2, H=2, all-head, K, bytes 0x00..0x0F back-to-back → 4 K writes, row r word = {4r+3, 4r+2, 4r+1, 4r} (slot 3..0), be=2'b11, writes at cycles 5/10/15/20, done at 21, V_we never high.
- Same params, single-head, V, head_idx=1, bytes 0xA0..0xA7 → 4 V writes at cycles 3/6/9/12, be=2'b10, row r slots 3:2 = {0xA0+2r+1, 0xA0+2r}, done at 13.
- Random in_valid gaps (50%) on the first test → identical RAM contents; in_ready is never high outside FILL.
- While busy on K, drive dut_V_addr=3 and dut_K_addr=2 → V_addr=3 immediately, K_addr=row; after done, K_addr=2. Pulse start mid-load → ignored.
- Assert rst during row 2 FILL → next cycle all outputs at reset values, no strobe. A new start then loads from row 0.
- Default params (166/44/4) full K load from a file-derived byte stream → RAM dump matches the file image byte-exact, done at cycle 166·177+1.

Source files
------------

// File: rtl/kv_ram_loader.sv
// Streams a byte-serial matrix image into the K or V multi-head RAM, one packed
// row (H heads x N bytes) per write; passes the engine's read addresses through when idle.
module kv_ram_loader #(
  parameter int M  = 166,
  parameter int N  = 44,
  parameter int H  = 4,
  parameter int AW = (M > 1) ? $clog2(M) : 1,
  parameter int HW = (H > 1) ? $clog2(H) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 sel_v,
  input  logic                 one_head,
  input  logic [HW-1:0]        head_idx,
  input  logic                 in_valid,
  input  logic [7:0]           in_data,
  output logic                 in_ready,
  input  logic [AW-1:0]        dut_K_addr,
  input  logic [AW-1:0]        dut_V_addr,
  output logic [AW-1:0]        K_addr,
  output logic [AW-1:0]        V_addr,
  output logic [H*N*8-1:0]     ram_data,
  output logic [H-1:0]         ram_be,
  output logic                 K_we,
  output logic                 V_we,
  output logic                 busy,
  output logic                 done
);
  localparam int S  = H * N;
  localparam int BW = (S > 1) ? $clog2(S) : 1;

  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;
  state_t state, state_nx;

  logic          sel_q, one_q;
  logic [BW-1:0] base_q, byte_q, last_c, slot_c;
  logic [AW-1:0] row_q;
  logic [HW-1:0] hidx_c;
  logic          row_end, last_row;

  // Out-of-range head indices land on the top head
  always_comb begin
    hidx_c = head_idx;
    if (int'(head_idx) >= H) hidx_c = HW'(H - 1);
  end

  assign last_c   = one_q ? BW'(N - 1) : BW'(S - 1);
  assign slot_c   = base_q + byte_q;
  assign row_end  = (byte_q == last_c);
  assign last_row = (row_q == AW'(M - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    K_we     = 1'b0;
    V_we     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE:  if (start) state_nx = FILL;
      FILL: begin
        in_ready = 1'b1;
        if (in_valid && row_end) state_nx = WRITE;
      end
      WRITE: begin
        K_we     = !sel_q;
        V_we     = sel_q;
        state_nx = last_row ? DONE : FILL;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Slot contents persist across rows; only enabled heads are ever rewritten
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q    <= 1'b0;
      one_q    <= 1'b0;
      base_q   <= '0;
      byte_q   <= '0;
      row_q    <= '0;
      ram_be   <= '0;
      ram_data <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          sel_q  <= sel_v;
          one_q  <= one_head;
          base_q <= one_head ? BW'(int'(hidx_c) * N) : '0;
          ram_be <= one_head ? (H'(1) << hidx_c) : '1;
          row_q  <= '0;
          byte_q <= '0;
        end
        FILL: if (in_valid) begin
          ram_data[{slot_c, 3'b000} +: 8] <= in_data;
          byte_q <= byte_q + 1'b1;
        end
        WRITE: if (!last_row) begin
          row_q  <= row_q + 1'b1;
          byte_q <= '0;
        end
        default: ;
      endcase
    end
  end

  assign busy   = (state != IDLE);
  assign K_addr = (busy && !sel_q) ? row_q : dut_K_addr;
  assign V_addr = (busy &&  sel_q) ? row_q : dut_V_addr;

endmodule

// File: tb/tb_kv_ram_loader.sv
// Bench for kv_ram_loader: small-parameter instance checked every cycle against a
// row-image/write-queue model, plus a default-parameter full K load.
module tb_kv_ram_loader;
  localparam int SM = 4, SN = 2, SH = 2;
  localparam int DM = 166, DN = 44, DH = 4;
  localparam int DL = DN * DH;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  bit mon_en = 1'b0;

  // small instance
  logic        s_start, s_sel_v, s_one, s_in_valid, s_in_ready;
  logic [0:0]  s_hidx;
  logic [7:0]  s_in_data;
  logic [1:0]  s_dK, s_dV, s_K_addr, s_V_addr, s_ram_be;
  logic [31:0] s_ram_data;
  logic        s_K_we, s_V_we, s_busy, s_done;

  kv_ram_loader #(.M(SM), .N(SN), .H(SH)) dut_s (
    .clk(clk), .rst(rst), .start(s_start), .sel_v(s_sel_v), .one_head(s_one),
    .head_idx(s_hidx), .in_valid(s_in_valid), .in_data(s_in_data), .in_ready(s_in_ready),
    .dut_K_addr(s_dK), .dut_V_addr(s_dV), .K_addr(s_K_addr), .V_addr(s_V_addr),
    .ram_data(s_ram_data), .ram_be(s_ram_be), .K_we(s_K_we), .V_we(s_V_we),
    .busy(s_busy), .done(s_done));

  // default instance
  logic          d_start, d_sel_v, d_one, d_in_valid, d_in_ready;
  logic [1:0]    d_hidx;
  logic [7:0]    d_in_data, d_dK, d_dV, d_K_addr, d_V_addr;
  logic [DL*8-1:0] d_ram_data;
  logic [3:0]    d_ram_be;
  logic          d_K_we, d_V_we, d_busy, d_done;

  kv_ram_loader dut_d (
    .clk(clk), .rst(rst), .start(d_start), .sel_v(d_sel_v), .one_head(d_one),
    .head_idx(d_hidx), .in_valid(d_in_valid), .in_data(d_in_data), .in_ready(d_in_ready),
    .dut_K_addr(d_dK), .dut_V_addr(d_dV), .K_addr(d_K_addr), .V_addr(d_V_addr),
    .ram_data(d_ram_data), .ram_be(d_ram_be), .K_we(d_K_we), .V_we(d_V_we),
    .busy(d_busy), .done(d_done));

  typedef struct { bit v; int addr; logic [31:0] data; logic [1:0] be; int cyc; } wr_t;

  wr_t         exp_q[$];
  wr_t         mw;
  logic [7:0]  src[$];
  logic [31:0] ramK[SM], ramV[SM], ramK_ref[SM];
  logic [31:0] mask;
  bit          m_active = 1'b0, m_sel = 1'b0;
  int          m_writes = 0, m_dones = 0, m_done_exp = -1, t0 = 0, rowm;
  logic [DL*8-1:0] dram[DM];
  int          d_writes = 0, d_done_cyc = -1, d_t0 = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] img(input int i);
    return 8'((i * 29 + (i >> 7) * 13 + 5) & 255);
  endfunction

  // Expected writes: row r carries src[r*L .. r*L+L-1] at slots base.., one strobe per row
  task automatic build_exp(input bit v, input bit one, input int hidx, input bit timed);
    int L    = one ? SN : SN * SH;
    int base = one ? hidx * SN : 0;
    wr_t w;
    exp_q.delete();
    for (int r = 0; r < SM; r++) begin
      w.v    = v;
      w.addr = r;
      w.data = '0;
      for (int j = 0; j < L; j++) w.data[8*(base+j) +: 8] = src[r*L+j];
      w.be   = one ? 2'(1 << hidx) : 2'b11;
      w.cyc  = timed ? (r + 1) * (L + 1) : -1;
      exp_q.push_back(w);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      rowm = (m_writes > SM - 1) ? SM - 1 : m_writes;
      chk("busy", s_busy, m_active);
      chk("k_addr", s_K_addr, (m_active && !m_sel) ? rowm : s_dK);
      chk("v_addr", s_V_addr, (m_active &&  m_sel) ? rowm : s_dV);
      if (s_in_ready) chk("rdy_only_in_fill", {s_busy, s_K_we, s_V_we, s_done}, 4'b1000);
      if (s_K_we || s_V_we) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: got K_we=%0b V_we=%0b expected none", s_K_we, s_V_we);
        end else begin
          mw = exp_q.pop_front();
          chk("wr_sel", {s_V_we, s_K_we}, mw.v ? 2'b10 : 2'b01);
          chk("wr_addr", mw.v ? s_V_addr : s_K_addr, mw.addr);
          chk("wr_be", s_ram_be, mw.be);
          mask = {{16{mw.be[1]}}, {16{mw.be[0]}}};
          chk("wr_data", s_ram_data & mask, mw.data & mask);
          if (mw.cyc >= 0) chk("wr_cycle", cyc - t0, mw.cyc);
        end
        for (int h = 0; h < SH; h++)
          if (s_ram_be[h]) begin
            if (s_K_we) ramK[s_K_addr][16*h +: 16] = s_ram_data[16*h +: 16];
            if (s_V_we) ramV[s_V_addr][16*h +: 16] = s_ram_data[16*h +: 16];
          end
        m_writes++;
      end
      if (s_done) begin
        chk("done_while_active", s_busy, m_active);
        if (m_done_exp >= 0) chk("done_cycle", cyc - t0, m_done_exp);
        m_dones++;
        m_active = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      chk("d_v_we", d_V_we, 1'b0);
      if (d_K_we) begin
        chk("d_addr", d_K_addr, d_writes);
        chk("d_be", d_ram_be, 4'hF);
        if (int'(d_K_addr) < DM) dram[d_K_addr] = d_ram_data;
        d_writes++;
      end
      if (d_done) d_done_cyc = cyc - d_t0;
    end
  end

  // One load on the small instance; rst_cyc >= 0 aborts it with a one-cycle reset
  task automatic run_load(input bit sel, input bit one, input bit hidx, input int gap, input int rst_cyc);
    int i = 0, cyc0;
    bit hs;
    @(posedge clk); #1;
    s_sel_v = sel; s_one = one; s_hidx = hidx; s_start = 1'b1;
    m_sel = sel; m_writes = 0; m_dones = 0; cyc0 = cyc; t0 = cyc;
    @(posedge clk); #1;
    s_start = 1'b0; m_active = 1'b1;
    s_sel_v = ~sel; s_one = ~one; s_hidx = ~hidx;
    while (m_active && cyc - cyc0 < 400) begin
      if (rst_cyc >= 0 && cyc - cyc0 == rst_cyc) begin
        rst = 1'b1; s_in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; m_active = 1'b0; exp_q.delete();
        chk("rst_ctl", {s_in_ready, s_K_we, s_V_we, s_busy, s_done}, 5'b0);
        chk("rst_be", s_ram_be, 2'b00);
        chk("rst_data", s_ram_data, 32'h0);
        return;
      end
      s_start    = (cyc - cyc0 == 7);
      s_in_valid = (i < src.size()) && (int'($urandom_range(99)) >= gap);
      s_in_data  = s_in_valid ? src[i] : 8'($urandom);
      @(negedge clk);
      hs = s_in_valid && s_in_ready;
      @(posedge clk); #1;
      if (hs) i++;
    end
    s_in_valid = 1'b0; s_start = 1'b0;
    if (m_active) begin
      checks++; errors++;
      $display("FAIL load_timeout: got busy after %0d cycles expected done", cyc - cyc0);
      m_active = 1'b0;
    end
    chk("writes", m_writes, SM);
    chk("dones", m_dones, 1);
  endtask

  task automatic fill_src(input int first, input int n);
    src.delete();
    for (int k = 0; k < n; k++) src.push_back(8'(first + k));
  endtask

  task automatic verify_dram();
    logic [DL*8-1:0] e;
    int fb;
    for (int r = 0; r < DM; r++) begin
      for (int j = 0; j < DL; j++) e[8*j +: 8] = img(r * DL + j);
      checks++;
      if (dram[r] !== e) begin
        errors++;
        fb = 0;
        while (fb < DL - 1 && dram[r][8*fb +: 8] === e[8*fb +: 8]) fb++;
        $display("FAIL d_row%0d byte%0d: got %0h expected %0h", r, fb, dram[r][8*fb +: 8], e[8*fb +: 8]);
      end
    end
  endtask

  initial begin
    int i;
    bit hs;
    s_start = 0; s_sel_v = 0; s_one = 0; s_hidx = 0; s_in_valid = 0; s_in_data = 0;
    s_dK = 2'd2; s_dV = 2'd3;
    d_start = 0; d_sel_v = 0; d_one = 0; d_hidx = 0; d_in_valid = 0; d_in_data = 0;
    d_dK = 8'd17; d_dV = 8'd99;
    for (int r = 0; r < SM; r++) begin ramK[r] = '0; ramV[r] = '0; end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_ctl", {s_in_ready, s_K_we, s_V_we, s_busy, s_done}, 5'b0);
    chk("reset_be", s_ram_be, 2'b00);
    chk("reset_data", s_ram_data, 32'h0);
    chk("reset_d_busy", {d_busy, d_in_ready, d_ram_be}, 6'b0);
    mon_en = 1'b1;

    // all-head K load, back-to-back, mid-load start pulse ignored
    fill_src(0, 16);
    build_exp(0, 0, 0, 1);
    m_done_exp = 21;
    run_load(0, 0, 0, 0, -1);
    for (int r = 0; r < SM; r++)
      chk("k_row", ramK[r], {8'(4*r+3), 8'(4*r+2), 8'(4*r+1), 8'(4*r)});
    chk("k_row1_lit", ramK[1], 32'h07060504);
    @(posedge clk); #1;
    chk("k_addr_idle", s_K_addr, 2'd2);
    chk("v_addr_idle", s_V_addr, 2'd3);
    ramK_ref = ramK;

    // single-head V load, head 1
    fill_src(8'hA0, 8);
    build_exp(1, 1, 1, 1);
    m_done_exp = 13;
    run_load(1, 1, 1, 0, -1);
    for (int r = 0; r < SM; r++)
      chk("v_head1", ramV[r][31:16], {8'(8'hA0 + 2*r + 1), 8'(8'hA0 + 2*r)});
    chk("v_row2_lit", ramV[2][31:16], 16'hA5A4);

    // same K image with 50% valid gaps
    for (int r = 0; r < SM; r++) ramK[r] = '0;
    fill_src(0, 16);
    build_exp(0, 0, 0, 0);
    m_done_exp = -1;
    run_load(0, 0, 0, 50, -1);
    for (int r = 0; r < SM; r++) chk("gap_same_ram", ramK[r], ramK_ref[r]);

    // reset during row 2 fill, then a clean reload from row 0
    build_exp(0, 0, 0, 1);
    run_load(0, 0, 0, 0, 12);
    for (int r = 0; r < SM; r++) ramK[r] = '0;
    fill_src(8'h40, 16);
    build_exp(0, 0, 0, 1);
    m_done_exp = 21;
    run_load(0, 0, 0, 0, -1);
    chk("reload_row0", ramK[0], 32'h43424140);
    chk("reload_row3", ramK[3], 32'h4F4E4D4C);

    // default parameters: full K load of the image stream
    @(posedge clk); #1;
    d_start = 1'b1; d_t0 = cyc;
    @(posedge clk); #1;
    d_start = 1'b0; d_in_valid = 1'b1; i = 0;
    while (i < DM * DL && cyc - d_t0 < 40000) begin
      d_in_data = img(i);
      @(negedge clk);
      hs = d_in_ready;
      @(posedge clk); #1;
      if (hs) i++;
    end
    d_in_valid = 1'b0;
    for (int k = 0; k < 50 && d_done_cyc < 0; k++) @(posedge clk);
    chk("d_done_cycle", d_done_cyc, 166 * 177 + 1);
    chk("d_writes", d_writes, DM);
    @(posedge clk); #1;
    chk("d_idle_addr", {d_busy, d_K_addr}, {1'b0, 8'd17});
    verify_dram();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
